// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, 1-cycle synchronous imem read, and a 2-entry valid/ready output queue.
// Optional macro BRANCH_PREDECODE_EN redirects fetch on B/BL words as they return from memory.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imemRd,
    output logic [ADDR_W-1:0] o_imemAddr,
    input  logic [31:0]       i_imemData,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [10:0]       o_opCode,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_predTaken,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_target,
    output logic              o_alignErr
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic              r_vld_p1;
    logic [ADDR_W-1:0] r_tag_pc_p1;
    logic [31:0]       r_q_instr [2];
    logic [ADDR_W-1:0] r_q_pc    [2];
    logic              r_q_pt    [2];
    logic              r_head;
    logic [CNT_W-1:0]  r_count;
    logic              r_align_err;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_occ;
    logic              w_wr_idx;
    logic              w_pd_hit;
    logic [ADDR_W-1:0] w_pd_target;

    // Occupancy the queue will have once this cycle's response lands and the pop retires.
    assign o_valid  = (r_count != '0);
    assign w_pop    = o_valid & i_ready;
    assign w_occ    = {1'b0, r_count} + (CNT_W+1)'(r_vld_p1) - (CNT_W+1)'(w_pop);
    assign w_issue  = !i_rst & !i_redirect & (w_occ < (CNT_W+1)'(QDEPTH));
    assign w_push   = r_vld_p1 & !i_redirect;
    assign w_wr_idx = r_head ^ r_count[0];

`ifdef BRANCH_PREDECODE_EN
    assign w_pd_hit    = w_push & ((i_imemData[31:26] == 6'b000101) ||
                                   (i_imemData[31:26] == 6'b100101));
    assign w_pd_target = r_tag_pc_p1 +
                         {{(ADDR_W-28){i_imemData[25]}}, i_imemData[25:0], 2'b00};
`else
    assign w_pd_hit    = 1'b0;
    assign w_pd_target = '0;
`endif

    // Stage p0: request issue and PC update; redirect outranks predecode outranks sequential.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= {i_target[ADDR_W-1:2], 2'b00};
        end else if (w_pd_hit) begin
            r_pc <= w_pd_target;
        end else if (w_issue) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    // Clearing r_vld_p1 is what discards a stale response after reset, redirect or predecode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1    <= 1'b0;
            r_count     <= '0;
            r_head      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_vld_p1    <= w_issue & !w_pd_hit;
            r_align_err <= i_redirect & (|i_target[1:0]);
            if (i_redirect) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                r_head  <= r_head ^ w_pop;
            end
        end
    end

    // Stage p1: response capture into the queue slot behind the current tail.
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_tag_pc_p1 <= r_pc;
        end
        if (w_push) begin
            r_q_instr[w_wr_idx] <= i_imemData;
            r_q_pc[w_wr_idx]    <= r_tag_pc_p1;
            r_q_pt[w_wr_idx]    <= w_pd_hit;
        end
    end

    assign o_imemRd    = w_issue;
    assign o_imemAddr  = r_pc;
    assign o_instr     = o_valid ? r_q_instr[r_head] : 32'h0;
    assign o_pc        = o_valid ? r_q_pc[r_head] : '0;
    assign o_predTaken = o_valid & r_q_pt[r_head];
    assign o_opCode    = o_instr[31:21];
    assign o_alignErr  = r_align_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: startup, stall, redirect, misaligned redirect, mid-stream reset, B predecode.
module tb_instr_fetch_unit;

    logic        clk;
    logic        i_rst;
    logic        o_imemRd;
    logic [63:0] o_imemAddr;
    logic [31:0] i_imemData;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [10:0] o_opCode;
    logic [63:0] o_pc;
    logic        o_predTaken;
    logic        i_redirect;
    logic [63:0] i_target;
    logic        o_alignErr;

    int n_checks;
    int n_fail;
    logic br_mode;

    localparam logic [31:0] ADD_W = 32'h8B020020;
    localparam logic [31:0] B_W   = 32'h14000004;

`ifdef BRANCH_PREDECODE_EN
    localparam logic [63:0] EXP_AFTER_B = 64'h18;
    localparam logic        EXP_PT_B    = 1'b1;
`else
    localparam logic [63:0] EXP_AFTER_B = 64'hC;
    localparam logic        EXP_PT_B    = 1'b0;
`endif

    instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .QDEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .o_imemRd    (o_imemRd),
        .o_imemAddr  (o_imemAddr),
        .i_imemData  (i_imemData),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_instr     (o_instr),
        .o_opCode    (o_opCode),
        .o_pc        (o_pc),
        .o_predTaken (o_predTaken),
        .i_redirect  (i_redirect),
        .i_target    (i_target),
        .o_alignErr  (o_alignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (br_mode && a == 64'h8) return B_W;
        return ADD_W;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: memory answers the read seen before the edge, in the cycle after it.
    task automatic tick();
        logic        rd_s;
        logic [63:0] addr_s;
        rd_s   = o_imemRd;
        addr_s = o_imemAddr;
        @(posedge clk);
        #1;
        i_imemData = rd_s ? mem_word(addr_s) : 32'hDEADBEEF;
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic redir, input logic [63:0] tgt);
        tick();
        i_rst      = rst;
        i_ready    = rdy;
        i_redirect = redir;
        i_target   = tgt;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        n_checks = 0; n_fail = 0; br_mode = 1'b0;
        i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_target = '0; i_imemData = '0;

        tick(); tick(); #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_rd",    64'(o_imemRd), 64'd0);
        check("rst_addr",  o_imemAddr, 64'h0);
        check("rst_instr", 64'(o_instr), 64'h0);
        check("rst_opc",   64'(o_opCode), 64'h0);
        check("rst_pc",    o_pc, 64'h0);
        check("rst_pt",    64'(o_predTaken), 64'd0);
        check("rst_aerr",  64'(o_alignErr), 64'd0);

        // Startup with i_ready held high: first valid in cycle 2, then one per cycle.
        cyc(0, 1, 0, 0);
        check("c0_valid", 64'(o_valid), 64'd0);
        check("c0_rd",    64'(o_imemRd), 64'd1);
        check("c0_addr",  o_imemAddr, 64'h0);
        cyc(0, 1, 0, 0);
        check("c1_valid", 64'(o_valid), 64'd0);
        check("c1_addr",  o_imemAddr, 64'h4);
        for (int k = 2; k <= 5; k++) begin
            cyc(0, 1, 0, 0);
            check("run_valid", 64'(o_valid), 64'd1);
            check("run_pc",    o_pc, 64'(4 * (k - 2)));
            check("run_addr",  o_imemAddr, 64'(4 * k));
            if (k == 2) begin
                check("run_instr", 64'(o_instr), 64'(ADD_W));
                check("run_opc",   64'(o_opCode), 64'h458);
            end
        end

        // Stall five cycles: queue fills to two, fetch stops, head holds.
        for (int k = 6; k <= 10; k++) begin
            cyc(0, 0, 0, 0);
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_pc",    o_pc, 64'h10);
            check("stall_rd",    64'(o_imemRd), 64'd0);
        end
        cyc(0, 1, 0, 0);
        check("rel_pc",   o_pc, 64'h10);
        check("rel_rd",   64'(o_imemRd), 64'd1);
        check("rel_addr", o_imemAddr, 64'h18);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0);
            check("rel_seq", o_pc, 64'(20 + 4 * k));
        end

        // Redirect to 0x100 while a response is arriving.
        cyc(0, 0, 1, 64'h100);
        check("redir_rd", 64'(o_imemRd), 64'd0);
        cyc(0, 1, 0, 0);
        check("redir_valid", 64'(o_valid), 64'd0);
        check("redir_aerr",  64'(o_alignErr), 64'd0);
        check("redir_rd2",   64'(o_imemRd), 64'd1);
        check("redir_addr",  o_imemAddr, 64'h100);
        cyc(0, 1, 0, 0);
        check("redir_valid2", 64'(o_valid), 64'd0);
        cyc(0, 1, 0, 0);
        check("redir_v3", 64'(o_valid), 64'd1);
        check("redir_pc", o_pc, 64'h100);
        cyc(0, 1, 0, 0);
        check("redir_pc2", o_pc, 64'h104);

        // Misaligned redirect combined with a pop.
        cyc(0, 1, 1, 64'h102);
        check("mis_pc", o_pc, 64'h108);
        check("mis_rd", 64'(o_imemRd), 64'd0);
        cyc(0, 1, 0, 0);
        check("mis_aerr",  64'(o_alignErr), 64'd1);
        check("mis_valid", 64'(o_valid), 64'd0);
        check("mis_addr",  o_imemAddr, 64'h100);
        cyc(0, 1, 0, 0);
        check("mis_aerr2", 64'(o_alignErr), 64'd0);
        cyc(0, 1, 0, 0);
        check("mis_pc2", o_pc, 64'h100);

        // One-cycle reset mid-stream; arrange for a B word at 0x8 afterwards.
        cyc(1, 1, 0, 0);
        br_mode = 1'b1;
        cyc(0, 1, 0, 0);
        check("mrst_valid", 64'(o_valid), 64'd0);
        check("mrst_pc",    o_pc, 64'h0);
        check("mrst_instr", 64'(o_instr), 64'h0);
        check("mrst_opc",   64'(o_opCode), 64'h0);
        check("mrst_pt",    64'(o_predTaken), 64'd0);
        check("mrst_aerr",  64'(o_alignErr), 64'd0);
        check("mrst_rd",    64'(o_imemRd), 64'd1);
        check("mrst_addr",  o_imemAddr, 64'h0);
        cyc(0, 1, 0, 0);
        check("mrst_valid2", 64'(o_valid), 64'd0);
        cyc(0, 1, 0, 0);
        check("mrst_v3",    64'(o_valid), 64'd1);
        check("mrst_pc3",   o_pc, 64'h0);
        check("mrst_instr3", 64'(o_instr), 64'(ADD_W));

        cyc(0, 1, 0, 0);
        check("b_pc4", o_pc, 64'h4);
        cyc(0, 1, 0, 0);
        check("b_pc8",   o_pc, 64'h8);
        check("b_instr", 64'(o_instr), 64'(B_W));
        check("b_opc",   64'(o_opCode), 64'h0A0);
        check("b_pt",    64'(o_predTaken), 64'(EXP_PT_B));
        cyc(0, 1, 0, 0);
        waited = 0;
        while (!o_valid && waited < 4) begin
            cyc(0, 1, 0, 0);
            waited++;
        end
        check("b_next_valid", 64'(o_valid), 64'd1);
        check("b_next_pc",    o_pc, EXP_AFTER_B);
        check("b_next_pt",    64'(o_predTaken), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
